// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer serving a word-addressed register memory
// Optional wait-state counter enabled by macro APB_WAIT_STATE_EN
module apb_slave_mem #(
    parameter int          SLV_ID      = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic              sel;
    logic              err;
    logic              ready_int;
    logic [31:0]       off;
    logic [IDX_W-1:0]  idx;

    assign sel = psel[SLV_ID];
    assign off = paddr - BASE_ADDR;
    assign err = (paddr < BASE_ADDR) || (off >= WIN_BYTES) || (paddr[1:0] != 2'b00);
    assign idx = off[IDX_W+1:2];

`ifdef APB_WAIT_STATE_EN
    logic [3:0] wait_cnt;
    assign ready_int = (state == ACCESS) && (wait_cnt == 4'(WAIT_CYCLES));
`else
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
    assign ready_int   = (state == ACCESS);
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= IDLE;
`ifdef APB_WAIT_STATE_EN
            wait_cnt <= 4'd0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // penable without a preceding SETUP is not a transfer
                    if (sel && !penable) begin
                        state <= ACCESS;
`ifdef APB_WAIT_STATE_EN
                        wait_cnt <= 4'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (!sel) begin
                        state <= IDLE;
                    end else if (ready_int) begin
                        if (penable) begin
                            if (pwrite && !err) begin
                                mem[idx] <= pwdata;
                            end
                            state <= IDLE;
                        end
                    end else begin
`ifdef APB_WAIT_STATE_EN
                        wait_cnt <= wait_cnt + 4'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even before the state register clears
    assign pready  = !hreset && ready_int;
    assign pslverr = pready && err;
    assign prdata  = (pready && !pwrite && !err) ? mem[idx] : 32'd0;

    logic unused_bits;
    assign unused_bits = ^{psel, off[31:IDX_W+2], off[1:0]};

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - randomized bench for three apb_slave_mem instances on one APB bus
module tb_apb_slave_mem;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam int          NSLV  = 3;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [2:0]  psel = 3'b000;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata_v  [NSLV];
    logic        pready_v  [NSLV];
    logic        pslverr_v [NSLV];

    logic [31:0] mem_m [NSLV][DEPTH];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    apb_slave_mem #(.SLV_ID(0), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_slv0 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]));
    apb_slave_mem #(.SLV_ID(1), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_slv1 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]));
    apb_slave_mem #(.SLV_ID(2), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_slv2 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]));

    function automatic int exp_wait(input int s);
`ifdef APB_WAIT_STATE_EN
        case (s)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
`else
        return (s < 0) ? 1 : 0;
`endif
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        return (a < BASE) || ((a - BASE) >= DEPTH * 4) || (a % 4 != 0);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NSLV; s++)
            for (int w = 0; w < DEPTH; w++)
                mem_m[s][w] = 32'd0;
    endtask

    task automatic bus_idle();
        @(posedge hclk); #1;
        psel = 3'b000;
        penable = 1'b0;
    endtask

    task automatic apb_xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int          cyc;
        bit          done;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        err_o;
        rd = 32'd0;
        err_o = 1'b0;
        exp_err = addr_err(addr);
        exp_rd = (!wr && !exp_err) ? mem_m[s][(addr - BASE) / 4] : 32'd0;
        @(posedge hclk); #1;
        psel = 3'(1 << s);
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        @(posedge hclk); #1;
        penable = 1'b1;
        cyc = 1;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge hclk);
            cyc++;
            for (int o = 0; o < NSLV; o++) begin
                if (o != s) begin
                    check_eq("unselected_pready", 32'(pready_v[o]), 32'd0);
                    check_eq("unselected_prdata", prdata_v[o], 32'd0);
                end
            end
            if (pready_v[s]) begin
                done = 1;
                rd = prdata_v[s];
                err_o = pslverr_v[s];
            end
        end
        check_eq("xfer_cycles", 32'(cyc), 32'(2 + exp_wait(s)));
        check_eq("pslverr", 32'(err_o), 32'(exp_err));
        check_eq(wr ? "write_prdata" : "read_prdata", rd, exp_rd);
        if (wr && !exp_err)
            mem_m[s][(addr - BASE) / 4] = data;
    endtask

    task automatic do_reset();
        @(posedge hclk); #1;
        hreset = 1'b1;
        psel = 3'b000;
        penable = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        for (int s = 0; s < NSLV; s++) begin
            check_eq("reset_pready", 32'(pready_v[s]), 32'd0);
            check_eq("reset_pslverr", 32'(pslverr_v[s]), 32'd0);
            check_eq("reset_prdata", prdata_v[s], 32'd0);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        model_clear();
        do_reset();

        // zero-wait write then read
        apb_xfer(0, 1, 32'h8000_0008, 32'hDEAD_BEEF);
        apb_xfer(0, 0, 32'h8000_0008, 32'd0);
        check_eq("deadbeef_model", mem_m[0][2], 32'hDEAD_BEEF);

        // wait-state slave
        apb_xfer(1, 1, 32'h8000_0004, 32'h1234_5678);
        apb_xfer(1, 0, 32'h8000_0004, 32'd0);

        // error responses leave memory intact
        apb_xfer(0, 1, 32'h8000_0000, 32'hA5A5_0001);
        apb_xfer(0, 1, 32'h8000_0040, 32'hBAD0_0040);
        apb_xfer(0, 1, 32'h8000_0006, 32'hBAD0_0006);
        apb_xfer(0, 1, 32'h7FFF_FFFC, 32'hBAD0_0000);
        apb_xfer(0, 0, 32'h8000_0040, 32'd0);
        apb_xfer(0, 0, 32'h8000_0000, 32'd0);

        // traffic for another slave must not disturb slave 0
        apb_xfer(1, 1, 32'h8000_0000, 32'hFFFF_0000);
        apb_xfer(0, 0, 32'h8000_0000, 32'd0);

        // penable without SETUP is ignored
        @(posedge hclk); #1;
        psel = 3'b001;
        penable = 1'b1;
        pwrite = 1'b1;
        paddr = BASE;
        pwdata = 32'h0BAD_0BAD;
        repeat (3) begin
            @(negedge hclk);
            check_eq("nosetup_pready", 32'(pready_v[0]), 32'd0);
        end
        bus_idle();
        apb_xfer(0, 0, 32'h8000_0000, 32'd0);

        // back-to-back INCR4-style writes and reads
        for (int i = 0; i < 4; i++)
            apb_xfer(0, 1, BASE + 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++)
            apb_xfer(0, 0, BASE + 32'(4 * i), 32'd0);
        bus_idle();

        // reset during ACCESS of a write discards it and clears memory
        @(posedge hclk); #1;
        psel = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h8000_0008;
        pwdata = 32'hCAFE_F00D;
        @(posedge hclk); #1;
        penable = 1'b1;
        hreset = 1'b1;
        @(negedge hclk);
        check_eq("midreset_pready", 32'(pready_v[2]), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        psel = 3'b000;
        penable = 1'b0;
        model_clear();
        @(negedge hclk);
        check_eq("postreset_pready", 32'(pready_v[2]), 32'd0);
        apb_xfer(2, 0, 32'h8000_0008, 32'd0);
        apb_xfer(0, 0, 32'h8000_0000, 32'd0);

        // randomized traffic against the memory model
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (kind == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (kind == 8) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 64));
            else               a = BASE - 32'(4 * $urandom_range(1, 64));
            apb_xfer($urandom_range(0, NSLV - 1), 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0)
                bus_idle();
        end
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
